pa_perips_uart_bridge: RTL

PA_PERIPS_UART_BRIDGE -- requirements
Module: pa_perips_uart_bridge

---
 rtl/pa_perips_uart_bridge_pkg.sv | 33 +++
 rtl/pa_perips_uart_bridge_if.sv | 13 +
 rtl/pa_perips_uart_phy.sv | 189 ++++++++++++++++++
 rtl/pa_perips_uart_bridge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pa_perips_uart_bridge_pkg.sv
// Shared constants and state encodings for the UART-to-bus bridge.
package pa_perips_uart_bridge_pkg;

  localparam int DATA_BUS_WIDTH = 32;
  localparam int CPU_FREQ_HZ    = 50_000_000;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    CMD_IDLE   = 3'd0,
    CMD_ADDR   = 3'd1,
    CMD_WDATA  = 3'd2,
    CMD_BUS    = 3'd3,
    CMD_RDWAIT = 3'd4,
    CMD_REPLY  = 3'd5
  } cmd_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/pa_perips_uart_bridge_if.sv
// Simple single-cycle strobe bus driven by the bridge.
interface pa_perips_uart_bridge_if;
  import pa_perips_uart_bridge_pkg::*;

  logic [DATA_BUS_WIDTH-1:0] addr_o;
  logic                      data_rd_o;
  logic                      data_we_o;
  logic [DATA_BUS_WIDTH-1:0] data_o;
  logic [DATA_BUS_WIDTH-1:0] data_i;

  modport master (output addr_o, output data_rd_o, output data_we_o, output data_o, input data_i);
  modport slave  (input addr_o, input data_rd_o, input data_we_o, input data_o, output data_i);
endinterface

// File: rtl/pa_perips_uart_phy.sv
// 8N1 UART receiver and transmitter with byte valid/ready handshakes.
module pa_perips_uart_phy
  import pa_perips_uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pad_rxd,
  output logic       pad_txd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_r;
  logic          rxd_prev_r;
  logic          rxd_s;
  rx_state_e     rx_state_r, rx_state_s;
  logic [CW-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]    rx_bit_r, rx_bit_s;
  logic [7:0]    rx_shift_r, rx_shift_s;
  logic [7:0]    rx_data_r, rx_data_s;
  logic          rx_valid_r, rx_valid_s;
  logic          rx_ferr_r, rx_ferr_s;

  tx_state_e     tx_state_r, tx_state_s;
  logic [CW-1:0] tx_cnt_r, tx_cnt_s;
  logic [8:0]    tx_shift_r, tx_shift_s;
  logic [3:0]    tx_left_r, tx_left_s;
  logic          txd_r, txd_s;

  assign rxd_s    = sync_r[1];
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign rx_ferr  = rx_ferr_r;
  assign pad_txd  = txd_r;
  assign tx_ready = (tx_state_r == TX_IDLE);

  // Receive next-state: start edge, mid-start glitch check, then bit-centre sampling.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_bit_s   = rx_bit_r;
    rx_shift_s = rx_shift_r;
    rx_data_s  = rx_data_r;
    rx_valid_s = 1'b0;
    rx_ferr_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rxd_prev_r && !rxd_s) begin
          rx_state_s = RX_START;
          rx_cnt_s   = CNT_ZERO;
        end else begin
          rx_state_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_s = CNT_ZERO;
          rx_bit_s = 3'd0;
          if (rxd_s) begin
            rx_state_s = RX_IDLE;
          end else begin
            rx_state_s = RX_DATA;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_shift_s = {rxd_s, rx_shift_r[7:1]};
          if (rx_bit_r == 3'd7) begin
            rx_state_s = RX_STOP;
          end else begin
            rx_bit_s = rx_bit_r + 3'd1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == BIT_LAST) begin
          rx_cnt_s   = CNT_ZERO;
          rx_state_s = RX_IDLE;
          if (rxd_s) begin
            rx_valid_s = 1'b1;
            rx_data_s  = rx_shift_r;
          end else begin
            rx_ferr_s = 1'b1;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        rx_state_s = RX_IDLE;
      end
    endcase
  end

  // Transmit next-state: a 9-bit shifter carries data plus stop behind the start bit.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_shift_s = tx_shift_r;
    tx_left_s  = tx_left_r;
    txd_s      = txd_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_s = TX_SEND;
          tx_shift_s = {1'b1, tx_data};
          tx_left_s  = 4'd9;
          tx_cnt_s   = CNT_ZERO;
          txd_s      = 1'b0;
        end else begin
          txd_s = 1'b1;
        end
      end
      TX_SEND: begin
        if (tx_cnt_r == BIT_LAST) begin
          tx_cnt_s = CNT_ZERO;
          if (tx_left_r == 4'd0) begin
            tx_state_s = TX_IDLE;
            txd_s      = 1'b1;
          end else begin
            txd_s      = tx_shift_r[0];
            tx_shift_s = {1'b0, tx_shift_r[8:1]};
            tx_left_s  = tx_left_r - 4'd1;
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_ONE;
        end
      end
      default: begin
        tx_state_s = TX_IDLE;
        txd_s      = 1'b1;
      end
    endcase
  end

  // PHY state registers; synchroniser and line outputs reset to the idle-high level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_r     <= 2'b11;
      rxd_prev_r <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_shift_r <= 9'h000;
      tx_left_r  <= 4'd0;
      txd_r      <= 1'b1;
    end else begin
      sync_r     <= {sync_r[0], pad_rxd};
      rxd_prev_r <= rxd_s;
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_shift_r <= rx_shift_s;
      rx_data_r  <= rx_data_s;
      rx_valid_r <= rx_valid_s;
      rx_ferr_r  <= rx_ferr_s;
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_shift_r <= tx_shift_s;
      tx_left_r  <= tx_left_s;
      txd_r      <= txd_s;
    end
  end

endmodule

// File: rtl/pa_perips_uart_bridge.sv
// UART command decoder driving a single-strobe bus master ('W'/'R' frames, 'K'/data/'E' replies).
module pa_perips_uart_bridge
  import pa_perips_uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = CPU_FREQ_HZ / 115200,
  parameter int TIMEOUT_BITS = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    pad_rxd,
  output logic                    pad_txd,
  output logic                    busy_o,
  pa_perips_uart_bridge_if.master bus
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_ZERO = TW'(0);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT);
  localparam logic [DATA_BUS_WIDTH-1:0] WORD_ZERO = {DATA_BUS_WIDTH{1'b0}};

  logic [7:0] rx_data_s;
  logic       rx_valid_s;
  logic       rx_ferr_s;
  logic [7:0] tx_data_s;
  logic       tx_valid_s;
  logic       tx_ready_s;

  cmd_state_e                state_r, state_s;
  logic                      is_write_r, is_write_s;
  logic [1:0]                idx_r, idx_s;
  logic [DATA_BUS_WIDTH-1:0] addr_sh_r, addr_sh_s;
  logic [DATA_BUS_WIDTH-1:0] data_sh_r, data_sh_s;
  logic [DATA_BUS_WIDTH-1:0] addr_r, addr_s;
  logic [DATA_BUS_WIDTH-1:0] wdata_r, wdata_s;
  logic [DATA_BUS_WIDTH-1:0] reply_r, reply_s;
  logic [2:0]                left_r, left_s;
  logic                      err_pend_r, err_pend_s;
  logic [TW-1:0]             to_cnt_r, to_cnt_s;
  logic                      rd_r, rd_s;
  logic                      we_r, we_s;
  logic                      busy_r, busy_s;

  pa_perips_uart_phy #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pad_rxd  (pad_rxd),
    .pad_txd  (pad_txd),
    .rx_data  (rx_data_s),
    .rx_valid (rx_valid_s),
    .rx_ferr  (rx_ferr_s),
    .tx_data  (tx_data_s),
    .tx_valid (tx_valid_s),
    .tx_ready (tx_ready_s)
  );

  assign bus.addr_o    = addr_r;
  assign bus.data_o    = wdata_r;
  assign bus.data_rd_o = rd_r;
  assign bus.data_we_o = we_r;
  assign busy_o        = busy_r;

  // Command FSM next-state, TX arbitration and bus strobe generation.
  always_comb begin
    state_s    = state_r;
    is_write_s = is_write_r;
    idx_s      = idx_r;
    addr_sh_s  = addr_sh_r;
    data_sh_s  = data_sh_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    reply_s    = reply_r;
    left_s     = left_r;
    err_pend_s = err_pend_r;
    to_cnt_s   = to_cnt_r;
    rd_s       = 1'b0;
    we_s       = 1'b0;
    tx_valid_s = 1'b0;
    tx_data_s  = 8'h00;

    // A queued 'E' may still be pending when a new command reaches REPLY, so it goes first.
    if (err_pend_r && tx_ready_s) begin
      tx_valid_s = 1'b1;
      tx_data_s  = RSP_ERR;
      err_pend_s = 1'b0;
    end else if ((state_r == CMD_REPLY) && tx_ready_s) begin
      tx_valid_s = 1'b1;
      tx_data_s  = reply_r[7:0];
      reply_s    = {8'h00, reply_r[DATA_BUS_WIDTH-1:8]};
      left_s     = left_r - 3'd1;
    end else begin
      tx_valid_s = 1'b0;
    end

    case (state_r)
      CMD_IDLE: begin
        idx_s    = 2'd0;
        to_cnt_s = TO_ZERO;
        if (rx_valid_s) begin
          if (rx_data_s == OP_WRITE) begin
            state_s    = CMD_ADDR;
            is_write_s = 1'b1;
          end else if (rx_data_s == OP_READ) begin
            state_s    = CMD_ADDR;
            is_write_s = 1'b0;
          end else begin
            err_pend_s = 1'b1;
          end
        end else begin
          state_s = CMD_IDLE;
        end
      end
      CMD_ADDR: begin
        if (rx_ferr_s) begin
          state_s = CMD_IDLE;
        end else if (rx_valid_s) begin
          addr_sh_s = {rx_data_s, addr_sh_r[DATA_BUS_WIDTH-1:8]};
          to_cnt_s  = TO_ZERO;
          if (idx_r == 2'd3) begin
            idx_s   = 2'd0;
            state_s = is_write_r ? CMD_WDATA : CMD_BUS;
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end else if (to_cnt_r == TO_LAST) begin
          state_s = CMD_IDLE;
        end else begin
          to_cnt_s = to_cnt_r + TO_ONE;
        end
      end
      CMD_WDATA: begin
        if (rx_ferr_s) begin
          state_s = CMD_IDLE;
        end else if (rx_valid_s) begin
          data_sh_s = {rx_data_s, data_sh_r[DATA_BUS_WIDTH-1:8]};
          to_cnt_s  = TO_ZERO;
          if (idx_r == 2'd3) begin
            idx_s   = 2'd0;
            state_s = CMD_BUS;
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end else if (to_cnt_r == TO_LAST) begin
          state_s = CMD_IDLE;
        end else begin
          to_cnt_s = to_cnt_r + TO_ONE;
        end
      end
      CMD_BUS: begin
        if (is_write_r) begin
          state_s = CMD_REPLY;
          reply_s = {{(DATA_BUS_WIDTH-8){1'b0}}, RSP_OK};
          left_s  = 3'd1;
        end else begin
          state_s = CMD_RDWAIT;
        end
      end
      CMD_RDWAIT: begin
        state_s = CMD_REPLY;
        reply_s = bus.data_i;
        left_s  = 3'd4;
      end
      CMD_REPLY: begin
        if (tx_ready_s && !err_pend_r && (left_r == 3'd1)) begin
          state_s = CMD_IDLE;
        end else begin
          state_s = CMD_REPLY;
        end
      end
      default: begin
        state_s = CMD_IDLE;
      end
    endcase

    // Address and write data are committed only when a complete frame reaches BUS.
    if ((state_s == CMD_BUS) && (state_r != CMD_BUS)) begin
      addr_s  = addr_sh_s;
      we_s    = is_write_r;
      rd_s    = !is_write_r;
      wdata_s = is_write_r ? data_sh_s : wdata_r;
    end else begin
      rd_s = 1'b0;
      we_s = 1'b0;
    end
  end

  assign busy_s = (state_s != CMD_IDLE);

  // Command FSM and registered bus outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= CMD_IDLE;
      is_write_r <= 1'b0;
      idx_r      <= 2'd0;
      addr_sh_r  <= WORD_ZERO;
      data_sh_r  <= WORD_ZERO;
      addr_r     <= WORD_ZERO;
      wdata_r    <= WORD_ZERO;
      reply_r    <= WORD_ZERO;
      left_r     <= 3'd0;
      err_pend_r <= 1'b0;
      to_cnt_r   <= TO_ZERO;
      rd_r       <= 1'b0;
      we_r       <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      is_write_r <= is_write_s;
      idx_r      <= idx_s;
      addr_sh_r  <= addr_sh_s;
      data_sh_r  <= data_sh_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      reply_r    <= reply_s;
      left_r     <= left_s;
      err_pend_r <= err_pend_s;
      to_cnt_r   <= to_cnt_s;
      rd_r       <= rd_s;
      we_r       <= we_s;
      busy_r     <= busy_s;
    end
  end

endmodule
